// File: rtl/lm80c_ps2_pkg.sv
// Shared types, frame constants and the parity helper for the PS/2 link blocks.
package lm80c_ps2_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } ps2_state_t;

    typedef enum logic {
        HIGH = 1'b0,
        LOW  = 1'b1
    } ps2_phase_t;

    // start + 8 data + parity + stop
    localparam int PS2_FRAME_BITS = 11;
    // idle time after each frame, in PS/2 half-bit periods
    localparam int PS2_GAP_HALVES = 4;

    // Odd parity bit: set when the data byte holds an even number of ones.
    function automatic logic ps2_odd_parity(input logic [7:0] b);
        return ~(^b);
    endfunction

endpackage

// File: rtl/ps2_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered count and flags.
// push is ignored while full, pop is ignored while empty; both are judged
// against the flags as registered in that cycle.
module ps2_sync_fifo #(
    parameter int W  = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    logic [W-1:0]  mem [2**AW];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_q;
    logic [AW:0]   count_n;
    logic          full_q;
    logic          empty_q;
    logic          do_push;
    logic          do_pop;

    assign do_push = push & ~full_q;
    assign do_pop  = pop & ~empty_q;

    // Next occupancy; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_n = count_q;
        case ({do_push, do_pop})
            2'b10:   count_n = count_q + 1'b1;
            2'b01:   count_n = count_q - 1'b1;
            default: count_n = count_q;
        endcase
    end

    // Pointers, count and flags; flags are registered from the next count.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count_q <= count_n;
            full_q  <= (count_n == DEPTH);
            empty_q <= (count_n == '0);
        end
    end

    // Storage array; contents need no reset since the pointers gate reads.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = full_q;
    assign empty = empty_q;
    assign count = count_q;

endmodule

// File: rtl/ps2_kbd_tx.sv
// Device-side PS/2 keyboard transmitter: queues scan-code bytes and sends each
// as an 11-bit frame (start, data LSB first, odd parity, stop) on ps2_clk/ps2_data.
//
// Write handshake: din is accepted on any cycle with wr=1 and full=0 (full as
// registered in that cycle). A write while full is dropped and overflow pulses
// for exactly the following cycle. There is no back-pressure beyond full.
module ps2_kbd_tx
    import lm80c_ps2_pkg::*;
#(
    parameter int PS2DIV  = 100,
    parameter int FIFO_AW = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       din,
    input  logic             wr,
    output logic             full,
    output logic             empty,
    output logic             busy,
    output logic             overflow,
    output logic             ps2_clk,
    output logic             ps2_data,
    output ps2_state_t       dbg_state,
    output logic [FIFO_AW:0] dbg_count
);

    localparam int DIV_W = (PS2DIV > 1) ? $clog2(PS2DIV) : 1;

    logic [7:0]       fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;

    ps2_state_t       state_q,  state_n;
    ps2_phase_t       phase_q,  phase_n;
    logic [DIV_W-1:0] div_q,    div_n;
    logic [3:0]       bit_q,    bit_n;
    logic [10:0]      shift_q,  shift_n;
    logic             clk_q,    clk_n;
    logic             busy_q,   busy_n;
    logic             overflow_q;
    logic             div_tc;

    ps2_sync_fifo #(
        .W  (8),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr),
        .pop   (pop),
        .din   (din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (dbg_count)
    );

    assign div_tc = (div_q == DIV_W'(PS2DIV - 1));

    // Next-state and next-output logic; shift_q[0] is the data line, and the
    // register refills with ones so the line is high outside a frame.
    always_comb begin
        state_n = state_q;
        phase_n = phase_q;
        div_n   = div_q;
        bit_n   = bit_q;
        shift_n = shift_q;
        clk_n   = clk_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                clk_n   = 1'b1;
                shift_n = '1;
                div_n   = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_n = {1'b1, ps2_odd_parity(fifo_dout), fifo_dout, 1'b0};
                    bit_n   = '0;
                    phase_n = HIGH;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (div_tc) begin
                    div_n = '0;
                    if (phase_q == HIGH) begin
                        // falling edge: receiver samples here, data held
                        phase_n = LOW;
                        clk_n   = 1'b0;
                    end else begin
                        // rising edge: the only moment data may change
                        clk_n   = 1'b1;
                        shift_n = {1'b1, shift_q[10:1]};
                        if (bit_q == 4'(PS2_FRAME_BITS - 1)) begin
                            bit_n   = '0;
                            shift_n = '1;
                            state_n = GAP;
                        end else begin
                            bit_n   = bit_q + 1'b1;
                            phase_n = HIGH;
                        end
                    end
                end else begin
                    div_n = div_q + 1'b1;
                end
            end
            GAP: begin
                // bit counter is reused to count idle half-bits
                clk_n   = 1'b1;
                shift_n = '1;
                if (div_tc) begin
                    div_n = '0;
                    if (bit_q == 4'(PS2_GAP_HALVES - 1)) begin
                        bit_n   = '0;
                        state_n = IDLE;
                    end else begin
                        bit_n = bit_q + 1'b1;
                    end
                end else begin
                    div_n = div_q + 1'b1;
                end
            end
            default: begin
                clk_n   = 1'b1;
                shift_n = '1;
                div_n   = '0;
                state_n = IDLE;
            end
        endcase
        busy_n = (state_n != IDLE);
    end

    // State and output registers; reset abandons any frame in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            phase_q    <= HIGH;
            div_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '1;
            clk_q      <= 1'b1;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_n;
            phase_q    <= phase_n;
            div_q      <= div_n;
            bit_q      <= bit_n;
            shift_q    <= shift_n;
            clk_q      <= clk_n;
            busy_q     <= busy_n;
            overflow_q <= wr & fifo_full;
        end
    end

    assign full      = fifo_full;
    assign empty     = fifo_empty;
    assign busy      = busy_q;
    assign overflow  = overflow_q;
    assign ps2_clk   = clk_q;
    assign ps2_data  = shift_q[0];
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Directed bench for ps2_kbd_tx with a frame-decoding monitor and scoreboard.
module tb_ps2_kbd_tx;
    import lm80c_ps2_pkg::*;

    localparam int D  = 4;
    localparam int AW = 4;
    localparam int PITCH = 26 * D + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    din = '0;
    logic          wr = 1'b0;
    logic          full, empty, busy, overflow, ps2_clk, ps2_data;
    ps2_state_t    dbg_state;
    logic [AW:0]   dbg_count;

    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;
    int t0       = 0;

    logic [7:0]  exp_q[$];
    logic [10:0] raw_q[$];
    int          fall_q[$];
    int          frame_t_q[$];

    ps2_kbd_tx #(.PS2DIV(D), .FIFO_AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .wr        (wr),
        .full      (full),
        .empty     (empty),
        .busy      (busy),
        .overflow  (overflow),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .dbg_state (dbg_state),
        .dbg_count (dbg_count)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_byte(input logic [7:0] b);
        din = b;
        wr  = 1'b1;
        tick();
        wr  = 1'b0;
    endtask

    task automatic wait_to(input int k);
        while (cyc - t0 < k) tick();
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (!(empty && !busy && exp_q.size() == 0) && n < budget) begin
            tick();
            n++;
        end
        check("drain_timeout", (n >= budget), 0);
    endtask

    // monitor: decode frames at falling edges, police the low phases
    logic [10:0] mon_bits = '0;
    int          mon_idx = 0;
    logic        mon_prev = 1'b1;
    logic        mon_in_low = 1'b0;
    int          mon_low_len = 0;
    logic        mon_low_data = 1'b1;
    logic        mon_low_bad = 1'b0;

    always @(posedge clk) begin
        #1;
        if (reset) begin
            mon_idx    = 0;
            mon_in_low = 1'b0;
            mon_prev   = ps2_clk;
        end else begin
            if (mon_prev && !ps2_clk) begin
                fall_q.push_back(cyc);
                if (mon_idx == 0) frame_t_q.push_back(cyc);
                mon_bits[mon_idx] = ps2_data;
                mon_idx++;
                mon_in_low   = 1'b1;
                mon_low_len  = 1;
                mon_low_data = ps2_data;
                mon_low_bad  = 1'b0;
                if (mon_idx == PS2_FRAME_BITS) begin
                    mon_idx = 0;
                    raw_q.push_back(mon_bits);
                    check("rx_fmt", {29'd0, mon_bits[0], mon_bits[10], mon_bits[9] == ~(^mon_bits[8:1])}, 32'd3);
                    if (exp_q.size() == 0) check("rx_unexpected", 1, 0);
                    else check("rx_byte", mon_bits[8:1], exp_q.pop_front());
                end
            end else if (!mon_prev && !ps2_clk) begin
                mon_low_len++;
                if (ps2_data !== mon_low_data) mon_low_bad = 1'b1;
            end else if (!mon_prev && ps2_clk && mon_in_low) begin
                check("low_len", mon_low_len, D);
                check("low_data_stable", mon_low_bad, 0);
                mon_in_low = 1'b0;
            end
            mon_prev = ps2_clk;
        end
    end

    initial begin
        int n;
        logic [7:0] b;

        // reset state
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_ps2_clk", ps2_clk, 1);
        check("rst_ps2_data", ps2_data, 1);
        check("rst_busy", busy, 0);
        check("rst_overflow", overflow, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_state", dbg_state, IDLE);

        // single byte 0x1C: latency and edge timing
        fall_q.delete(); raw_q.delete();
        t0 = cyc;
        exp_q.push_back(8'h1C);
        wr_byte(8'h1C);
        check("c1_empty", empty, 0);
        tick();
        check("c2_busy", busy, 1);
        check("c2_start_bit", ps2_data, 0);
        check("c2_state", dbg_state, SHIFT);
        n = 0;
        while (busy && n < 400) begin tick(); n++; end
        check("busy_fall_cycle", cyc - t0, 106);
        check("fall_count", fall_q.size(), 11);
        if (fall_q.size() == 11) begin
            check("first_fall", fall_q[0] - t0, 6);
            check("bit4_fall", fall_q[5] - t0, 46);
            check("last_fall", fall_q[10] - t0, 86);
        end
        drain(50);
        check("raw_1c", raw_q.size() > 0 ? raw_q[0] : 11'd0, 11'h438);

        // 0x00 and 0xFF back to back
        raw_q.delete(); frame_t_q.delete();
        exp_q.push_back(8'h00); exp_q.push_back(8'hFF);
        wr_byte(8'h00);
        tick();
        wr_byte(8'hFF);
        drain(600);
        check("raw_count_00ff", raw_q.size(), 2);
        if (raw_q.size() == 2) begin
            check("raw_00", raw_q[0], 11'h600);
            check("raw_ff", raw_q[1], 11'h7FE);
            check("pitch_00ff", frame_t_q[1] - frame_t_q[0], PITCH);
        end

        // burst of 18 writes: 17 accepted, one overflow
        raw_q.delete(); frame_t_q.delete();
        t0 = cyc;
        for (int i = 0; i < 18; i++) begin
            din = 8'(i + 1);
            wr  = 1'b1;
            if (i < 17) exp_q.push_back(8'(i + 1));
            tick();
            check("burst_overflow", overflow, (i == 17));
            if (i == 16) check("burst_full", full, 1);
        end
        wr = 1'b0;
        tick();
        check("burst_overflow_end", overflow, 0);
        drain(17 * PITCH + 200);
        check("burst_frames", raw_q.size(), 17);
        for (int i = 0; i + 1 < frame_t_q.size(); i++)
            check("burst_pitch", frame_t_q[i + 1] - frame_t_q[i], PITCH);

        // simultaneous push and pop at count 5
        t0 = cyc;
        exp_q.push_back(8'h21);
        wr_byte(8'h21);
        wait_to(3);
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back(8'(8'h22 + k));
            wr_byte(8'(8'h22 + k));
        end
        check("pp_count_before", dbg_count, 5);
        wait_to(106);
        check("pp_idle_busy", busy, 0);
        check("pp_count_at_pop", dbg_count, 5);
        exp_q.push_back(8'h27);
        wr_byte(8'h27);
        check("pp_count_after", dbg_count, 5);
        check("pp_empty", empty, 0);
        check("pp_full", full, 0);
        check("pp_busy", busy, 1);
        drain(7 * PITCH + 200);

        // reset during data bit 4, then a clean 0xAA frame
        t0 = cyc;
        exp_q.push_back(8'h55); exp_q.push_back(8'h66);
        wr_byte(8'h55);
        wr_byte(8'h66);
        wait_to(44);
        reset = 1'b1;
        tick();
        check("mid_rst_clk", ps2_clk, 1);
        check("mid_rst_data", ps2_data, 1);
        check("mid_rst_empty", empty, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_count", dbg_count, 0);
        reset = 1'b0;
        exp_q.delete();
        raw_q.delete();
        repeat (2) tick();
        exp_q.push_back(8'hAA);
        wr_byte(8'hAA);
        drain(PITCH + 100);
        check("aa_frames", raw_q.size(), 1);
        check("raw_aa", raw_q.size() > 0 ? raw_q[0] : 11'd0, 11'h754);

        // random traffic at random spacing
        for (int i = 0; i < 8; i++) begin
            n = $urandom_range(0, 150);
            repeat (n) tick();
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            wr_byte(b);
        end
        drain(8 * PITCH + 400);
        check("final_state", dbg_state, IDLE);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    // global watchdog
    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_errs + 1, n_checks + 1);
        $fatal(1, "watchdog");
    end

endmodule
